// File: rtl/ram_bus_master.sv
// ram_bus_master: single-outstanding initiator for the synchronous byte RAM bus.
// Optional WRITE_VERIFY_EN: every write is read back and compared before the response.
module ram_bus_master #(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 8,
   parameter int MEM_DEPTH = 10000,
   parameter int READ_WAIT = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic              chipsel,
   output logic              writeEn,
   output logic              readEn,
   output logic [DATA_W-1:0] busIn,
   output logic [ADDR_W-1:0] addrIn,
   input  logic [DATA_W-1:0] busOut
);

   if (READ_WAIT < 2 || READ_WAIT > 15) begin : g_bad_read_wait
      $error("READ_WAIT must lie within 2..15");
   end

   localparam logic [3:0]      WAIT_LAST = 4'(READ_WAIT - 1);
   localparam logic [ADDR_W:0] DEPTH     = (ADDR_W+1)'(MEM_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WRITE    = 3'd1,
      S_READ     = 3'd2,
      S_CAPTURE  = 3'd3,
      S_RESP     = 3'd4,
      S_VFY_READ = 3'd5,
      S_VFY_CAP  = 3'd6
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        wait_q, wait_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              rsp_err_q, rsp_err_d;
   logic              rsp_valid_q;
   logic              cs_q, wr_en_q, rd_en_q;
   logic [DATA_W-1:0] bus_in_q;
   logic [ADDR_W-1:0] addr_in_q;
   logic              run_q;

   logic              accept;
   logic              out_of_range;
   logic              wr_strobe_d;
   logic              rd_strobe_d;

   // run_q delays readiness to the first edge after reset release
   assign req_ready    = (state_q == S_IDLE) && run_q;
   assign accept       = req_valid && req_ready;
   assign out_of_range = ({1'b0, req_addr} >= DEPTH);

   always_comb begin
      state_d    = state_q;
      wait_d     = wait_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               addr_d     = req_addr;
               wdata_d    = req_wdata;
               rsp_data_d = '0;
               rsp_err_d  = out_of_range;
               if (out_of_range) begin
                  state_d = S_RESP;
               end else if (req_write) begin
                  state_d = S_WRITE;
               end else begin
                  state_d = S_READ;
                  wait_d  = WAIT_LAST;
               end
            end
         end
         S_WRITE: begin
`ifdef WRITE_VERIFY_EN
            state_d = S_VFY_READ;
            wait_d  = WAIT_LAST;
`else
            state_d = S_RESP;
`endif
         end
         S_READ: begin
            if (wait_q == 4'd0) begin
               state_d = S_CAPTURE;
            end else begin
               wait_d = wait_q - 4'd1;
            end
         end
         S_CAPTURE: begin
            rsp_data_d = busOut;
            state_d    = S_RESP;
         end
`ifdef WRITE_VERIFY_EN
         S_VFY_READ: begin
            if (wait_q == 4'd0) begin
               state_d = S_VFY_CAP;
            end else begin
               wait_d = wait_q - 4'd1;
            end
         end
         S_VFY_CAP: begin
            rsp_data_d = busOut;
            rsp_err_d  = (busOut != wdata_q);
            state_d    = S_RESP;
         end
`endif
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Strobes are registered from the next state so they leave the flops glitch-free
   assign wr_strobe_d = (state_d == S_WRITE);
   assign rd_strobe_d = (state_d == S_READ) || (state_d == S_VFY_READ);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         wait_q      <= 4'd0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         cs_q        <= 1'b0;
         wr_en_q     <= 1'b0;
         rd_en_q     <= 1'b0;
         bus_in_q    <= '0;
         addr_in_q   <= '0;
         run_q       <= 1'b0;
      end else begin
         run_q       <= 1'b1;
         state_q     <= state_d;
         wait_q      <= wait_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         rsp_valid_q <= (state_d == S_RESP);
         cs_q        <= wr_strobe_d | rd_strobe_d;
         wr_en_q     <= wr_strobe_d;
         rd_en_q     <= rd_strobe_d;
         if (wr_strobe_d || rd_strobe_d) begin
            addr_in_q <= addr_d;
         end
         if (wr_strobe_d) begin
            bus_in_q <= wdata_d;
         end
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   assign chipsel   = cs_q;
   assign writeEn   = wr_en_q;
   assign readEn    = rd_en_q;
   assign busIn     = bus_in_q;
   assign addrIn    = addr_in_q;

endmodule

// File: tb/tb_ram_bus_master.sv
// Directed bench for ram_bus_master: transaction-level model plus a per-cycle compare process.
`timescale 1ns/1ps
module tb_ram_bus_master;
   localparam int RW    = 2;
   localparam int DEPTH = 10000;
`ifdef WRITE_VERIFY_EN
   localparam int W_LAT    = RW + 3;
   localparam int W_A5_PIN = 'hA5;
   localparam int DROP_ERR = 1;
`else
   localparam int W_LAT    = 2;
   localparam int W_A5_PIN = 0;
   localparam int DROP_ERR = 0;
`endif

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [15:0] req_addr  = 16'h0000;
   logic [7:0]  req_wdata = 8'h00;
   logic [7:0]  busOut    = 8'h00;
   logic        req_ready, rsp_valid, rsp_err, chipsel, writeEn, readEn;
   logic [7:0]  rsp_data, busIn;
   logic [15:0] addrIn;

   always #5 clk = ~clk;

   ram_bus_master #(
      .ADDR_W(16), .DATA_W(8), .MEM_DEPTH(DEPTH), .READ_WAIT(RW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .chipsel(chipsel), .writeEn(writeEn), .readEn(readEn),
      .busIn(busIn), .addrIn(addrIn), .busOut(busOut)
   );

   // RAM model: a read needs two strobed edges; the first forwards whatever was staged before
   logic [7:0] ram [0:65535] = '{default: 8'h00};
   logic [7:0] ram_pipe = 8'hEE;
   logic       drop_wr  = 1'b0;
   always @(posedge clk) begin
      if (chipsel && writeEn && !drop_wr && int'(addrIn) < DEPTH) ram[addrIn] <= busIn;
      if (chipsel && readEn) begin
         busOut   <= ram_pipe;
         ram_pipe <= (int'(addrIn) < DEPTH) ? ram[addrIn] : 8'hFF;
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         acc;
      int         lat;
      logic       wr;
      logic [15:0] addr;
      logic [7:0] wdata;
      logic [7:0] data;
      logic       err;
      int         n_wr;
      int         n_rd;
      int         p_lat;
      int         p_data;
      int         p_err;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] ref_mem [0:65535] = '{default: 8'h00};
   int         tmo_cnt = 0;

   // Model: expected response of one accepted request, from the bus rules alone
   task automatic do_req(input logic wr, input logic [15:0] a, input logic [7:0] d,
                         input int p_lat, input int p_data, input int p_err);
      exp_t e;
      int   w;
      @(negedge clk);
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
      w = 0;
      while (!req_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!req_ready) begin
         $display("FAIL req_ready_timeout addr=0x%h: req_ready=0 required 1", a);
         tmo_cnt++;
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      e.acc = cyc; e.wr = wr; e.addr = a; e.wdata = d;
      e.p_lat = p_lat; e.p_data = p_data; e.p_err = p_err;
      if (int'(a) >= DEPTH) begin
         e.err = 1'b1; e.data = 8'h00; e.lat = 1; e.n_wr = 0; e.n_rd = 0;
      end else if (wr) begin
         if (!drop_wr) ref_mem[a] = d;
         e.n_wr = 1;
`ifdef WRITE_VERIFY_EN
         e.data = ref_mem[a]; e.err = (ref_mem[a] != d); e.lat = RW + 3; e.n_rd = RW;
`else
         e.data = 8'h00; e.err = 1'b0; e.lat = 2; e.n_rd = 0;
`endif
      end else begin
         e.data = ref_mem[a]; e.err = 1'b0; e.lat = RW + 2; e.n_wr = 0; e.n_rd = RW;
      end
      exp_q.push_back(e);
   endtask

   int   n_cmp = 0;
   int   n_bad = 0;
   int   rd_idx = 0;
   int   tmo_seen = 0;
   int   wr_seen = 0;
   int   rd_seen = 0;
   int   lat;
   exp_t cur;

   task automatic chk(input string nm, input int act, input int req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got 0x%0h required 0x%0h", nm, cyc, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (tmo_cnt != tmo_seen) begin
         n_cmp++;
         n_bad++;
         tmo_seen = tmo_cnt;
      end
      if (!rst_n) begin
         chk("rst_ctrl", int'({req_ready, rsp_valid, rsp_err, chipsel, writeEn, readEn}), 0);
         chk("rst_addrIn", int'(addrIn), 0);
         chk("rst_busIn", int'(busIn), 0);
         chk("rst_rsp_data", int'(rsp_data), 0);
         rd_idx  = exp_q.size();
         wr_seen = 0;
         rd_seen = 0;
      end else begin
         chk("strobe_excl", chipsel ? int'(writeEn ^ readEn) : int'(!(writeEn | readEn)), 1);
         if (rd_idx >= exp_q.size()) begin
            chk("idle_quiet", int'({rsp_valid, chipsel}), 0);
         end else begin
            cur = exp_q[rd_idx];
            if (chipsel) begin
               wr_seen += int'(writeEn);
               rd_seen += int'(readEn);
               chk("addrIn", int'(addrIn), int'(cur.addr));
               if (writeEn) chk("busIn", int'(busIn), int'(cur.wdata));
            end
            if (rsp_valid || cyc >= cur.acc + cur.lat - 1) begin
               lat = cyc - cur.acc + 1;
               chk("rsp_valid", int'(rsp_valid), 1);
               chk("latency", lat, cur.lat);
               chk("rsp_data", int'(rsp_data), int'(cur.data));
               chk("rsp_err", int'(rsp_err), int'(cur.err));
               chk("write_cycles", wr_seen, cur.n_wr);
               chk("read_cycles", rd_seen, cur.n_rd);
               if (cur.p_lat >= 0)  chk("pin_latency", lat, cur.p_lat);
               if (cur.p_data >= 0) chk("pin_data", int'(rsp_data), cur.p_data);
               if (cur.p_err >= 0)  chk("pin_err", int'(rsp_err), cur.p_err);
               $display("txn %0d: wr=%0d addr=0x%h wdata=0x%h -> data=0x%h err=%0d lat=%0d",
                        rd_idx, cur.wr, cur.addr, cur.wdata, rsp_data, rsp_err, lat);
               rd_idx++;
               wr_seen = 0;
               rd_seen = 0;
            end
         end
      end
   end

   task automatic wait_done();
      int w;
      w = 0;
      while (rd_idx < exp_q.size() && w < 40) begin
         @(negedge clk);
         w++;
      end
      if (rd_idx < exp_q.size()) begin
         $display("FAIL rsp_timeout: pending=%0d required 0", exp_q.size() - rd_idx);
         tmo_cnt++;
      end
      @(negedge clk);
   endtask

   initial begin
      // Request held during reset must not be taken until reset is released
      req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0010; req_wdata = 8'hA5;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;

      do_req(1'b1, 16'h0010, 8'hA5, W_LAT, W_A5_PIN, 0);  wait_done();
      do_req(1'b0, 16'h0010, 8'h00, 4, 'hA5, 0);          wait_done();
      do_req(1'b0, 16'h2710, 8'h00, 1, 0, 1);             wait_done();
      do_req(1'b1, 16'h2710, 8'h11, 1, 0, 1);             wait_done();
      do_req(1'b0, 16'hFFFF, 8'h00, 1, 0, 1);             wait_done();
      do_req(1'b1, 16'h270F, 8'h5A, W_LAT, -1, 0);        wait_done();
      do_req(1'b0, 16'h270F, 8'h00, 4, 'h5A, 0);          wait_done();

      do_req(1'b0, 16'h0010, 8'h00, 4, 'hA5, 0);
      do_req(1'b0, 16'h270F, 8'h00, 4, 'h5A, 0);
      wait_done();

      // Abandon a read in its first strobe cycle; the retry must return fresh data
      do_req(1'b1, 16'h0020, 8'h3C, W_LAT, -1, 0);        wait_done();
      do_req(1'b0, 16'h0020, 8'h00, -1, -1, -1);
      #1 rst_n = 1'b0;
      #5 rst_n = 1'b1;
      repeat (4) @(negedge clk);
      do_req(1'b0, 16'h0020, 8'h00, 4, 'h3C, 0);          wait_done();

      drop_wr = 1'b1;
      do_req(1'b1, 16'h0005, 8'h77, W_LAT, 0, DROP_ERR);  wait_done();
      drop_wr = 1'b0;
      do_req(1'b0, 16'h0005, 8'h00, 4, 0, 0);             wait_done();

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end
endmodule

// File: doc/ram_bus_master.md
Name: ram_bus_master

Overview:
- Initiator for the team's synchronous byte RAM bus: chip select, write enable, read enable, 8-bit data in/out and 16-bit address.
- Accepts single read/write requests from a client (CPU core, loader, DMA) over a valid/ready handshake.
- Sequences the RAM strobes, including the RAM's two-edge read latency.
- Returns one response per request.

Parameters:
- ADDR_W, 16, address width; matches the RAM address bus.
- DATA_W, 8, data width; matches the RAM data bus.
- MEM_DEPTH, 10000, number of valid RAM locations; addresses >= MEM_DEPTH are rejected.
- READ_WAIT, 2, clock edges chipsel&readEn are held per read; legal range 2..15.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  client request present.
- req_ready  out  1  master can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_data  out  DATA_W  read data (0 for writes).
- rsp_err  out  1  request rejected or verify mismatch; valid with rsp_valid.
- chipsel  out  1  RAM chip select.
- writeEn  out  1  RAM write enable.
- readEn  out  1  RAM read enable.
- busIn  out  DATA_W  data to RAM.
- addrIn  out  ADDR_W  address to RAM.
- busOut  in  DATA_W  data from RAM.

Behaviour:
- Reset:
  - Async assert: all outputs 0 immediately; state IDLE; wait counter 0.
  - Deassert is sampled synchronously; outputs stay 0 until the first request.
- req_ready = 1 only in IDLE with rst_n high. A request is accepted on an edge where req_valid & req_ready; req_addr, req_wdata and req_write are latched.
- Out-of-range address (req_addr >= MEM_DEPTH): no strobes; RESP next cycle with rsp_err=1, rsp_data=0.
- State machine: IDLE, WRITE, READ, CAPTURE, RESP (plus VFY_READ and VFY_CAP under the option).
  - IDLE -> WRITE on write accept; IDLE -> READ on read accept.
  - WRITE: chipsel=writeEn=1, readEn=0, addrIn/busIn driven for exactly one cycle -> RESP.
  - READ: chipsel=readEn=1, writeEn=0, addrIn held for READ_WAIT consecutive cycles (counter counts down) -> CAPTURE.
  - CAPTURE: strobes 0; busOut registered into rsp_data -> RESP.
  - RESP: rsp_valid=1 for exactly one cycle -> IDLE.
- Latency, accept edge to rsp_valid high:
  - write: 2 cycles.
  - read: READ_WAIT+2 cycles.
  - error: 1 cycle.
- Throughput: one request in flight; next accept no earlier than the cycle rsp_valid is high, so back-to-back reads give an IDLE cycle between transactions.
- READ_WAIT >= 2 is mandatory. The RAM may carry a stale internal read flag (e.g. after master reset mid-read); the first read edge can forward stale data and only the second edge guarantees fresh data.
- chipsel is never high without exactly one of writeEn/readEn; writeEn and readEn are never both high.
- addrIn/busIn hold their last driven value when strobes are low; they are 0 after reset.
- Reset mid-operation: the transaction is abandoned and no response is issued; a RAM write already clocked stays committed.
- req_valid low while in IDLE: no activity; strobes stay 0.

Optional Feature:
- Macro WRITE_VERIFY_EN.
- Defined:
  - After WRITE, the FSM goes to VFY_READ (READ_WAIT cycles of read strobes on the same address), then VFY_CAP, then RESP.
  - rsp_err=1 if captured busOut != latched wdata; rsp_data = read-back value.
  - Write latency becomes READ_WAIT+3.
- Undefined: no verify states; write latency 2; rsp_err for writes only flags out-of-range.

Test Plan:
- Reset with req_valid=1 held -> all outputs 0, req_ready=0 while rst_n=0; after release req_ready=1 and the first request is accepted.
- Write addr 0x0010 data 0xA5 -> one cycle chipsel=writeEn=1, addrIn=0x0010, busIn=0xA5; rsp_valid 2 cycles after accept, rsp_err=0.
- Read addr 0x0010 after that write, READ_WAIT=2 -> chipsel=readEn=1 for 2 cycles; rsp_valid 4 cycles after accept with rsp_data=0xA5.
- Read addr 0x2710 (10000) -> no strobes ever; rsp_valid next cycle, rsp_err=1, rsp_data=0x00.
- rst_n pulsed low during the first read cycle to 0x0020, then read 0x0020 (holding 0x3C) -> no response for the aborted read; second read returns 0x3C, not stale data.
- WRITE_VERIFY_EN with RAM write path forced to drop writes: write 0x0005=0x77 over a location holding 0x00 -> rsp_err=1, rsp_data=0x00, latency 5 cycles.
